// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from WB: drives the TLB search/read/write ports,
// returns TLBP/TLBR results to CP0 and requests a refetch after translation changes.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_pc,
  output logic              req_ready,
  input  logic              wb_ex,
  input  logic              mtc0_hazard,
  input  logic [31:0]       c0_entryhi,
  input  logic [31:0]       c0_index,
  output logic [18:0]       s_vpn2,
  output logic [7:0]        s_asid,
  input  logic              s_found,
  input  logic [IDX_W-1:0]  s_index,
  output logic [IDX_W-1:0]  r_index,
  output logic              tlbr_we,
  output logic              tlbp_we,
  output logic              tlbp_found,
  output logic [IDX_W-1:0]  tlbp_index,
  output logic              we,
  output logic [IDX_W-1:0]  w_index,
  output logic              refetch_req,
  output logic [31:0]       refetch_pc,
  output logic              busy
);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;
  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLBNUM - 1);

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, DONE} state_t;

  state_t             state_p0, state_nxt;
  logic [1:0]         op_p0;
  logic [31:0]        pc_p0;
  logic               found_p1;
  logic [IDX_W-1:0]   hit_idx_p1;
  logic [IDX_W-1:0]   rand_cnt;

  // Bits of the CP0 registers this block never looks at (EntryHi[12:8], Index.P and above).
  logic unused_c0_bits;
  assign unused_c0_bits = ^{c0_entryhi[12:8], c0_index[31:IDX_W]};

  function automatic logic [IDX_W-1:0] rand_next(input logic [IDX_W-1:0] cur);
    return (cur == '0) ? RAND_TOP : cur - IDX_W'(1);
  endfunction

  function automatic logic [31:0] pc_after(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_p0   <= IDLE;
      op_p0      <= '0;
      pc_p0      <= '0;
      found_p1   <= 1'b0;
      hit_idx_p1 <= '0;
      rand_cnt   <= RAND_TOP;
    end else begin
      state_p0 <= state_nxt;
      rand_cnt <= rand_next(rand_cnt);
      if (state_p0 == IDLE && req_valid && !wb_ex) begin
        op_p0 <= req_op;
        pc_p0 <= req_pc;
      end
      // search result is captured at the end of EXEC and reported in DONE
      if (state_p0 == EXEC && op_p0 == OP_TLBP) begin
        found_p1   <= s_found;
        hit_idx_p1 <= s_index;
      end
    end
  end

  always_comb begin
    state_nxt   = state_p0;
    req_ready   = 1'b0;
    s_vpn2      = '0;
    s_asid      = '0;
    r_index     = '0;
    tlbr_we     = 1'b0;
    tlbp_we     = 1'b0;
    tlbp_found  = 1'b0;
    tlbp_index  = '0;
    we          = 1'b0;
    w_index     = '0;
    refetch_req = 1'b0;
    refetch_pc  = '0;
    busy        = (state_p0 != IDLE) || req_valid;
    unique case (state_p0)
      IDLE: begin
        if (req_valid && !wb_ex) state_nxt = mtc0_hazard ? WAIT : EXEC;
      end
      WAIT: begin
        if (wb_ex)             state_nxt = IDLE;
        else if (!mtc0_hazard) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = DONE;
        unique case (op_p0)
          OP_TLBP: begin
            s_vpn2 = c0_entryhi[31:13];
            s_asid = c0_entryhi[7:0];
          end
          OP_TLBR: begin
            r_index = c0_index[IDX_W-1:0];
            tlbr_we = 1'b1;
          end
          OP_TLBWI: begin
            we      = 1'b1;
            w_index = c0_index[IDX_W-1:0];
          end
          OP_TLBWR: begin
            we      = 1'b1;
            w_index = rand_cnt;
          end
          default: ;
        endcase
      end
      DONE: begin
        state_nxt = IDLE;
        req_ready = 1'b1;
        if (op_p0 == OP_TLBP) begin
          tlbp_we    = 1'b1;
          tlbp_found = found_p1;
          tlbp_index = found_p1 ? hit_idx_p1 : '0;
        end else begin
          refetch_req = 1'b1;
          refetch_pc  = pc_after(pc_p0);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: directed vector table, hand-written abort/reset/random-index
// sequences, and randomized transactions checked cycle by cycle against a TLB model.
module tb_tlb_op_ctrl;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic resetn, req_valid, req_ready, wb_ex, mtc0_hazard;
  logic [1:0] req_op;
  logic [31:0] req_pc, c0_entryhi, c0_index, refetch_pc;
  logic [18:0] s_vpn2;
  logic [7:0] s_asid;
  logic s_found, tlbr_we, tlbp_we, tlbp_found, we, refetch_req, busy;
  logic [IDX_W-1:0] s_index, r_index, tlbp_index, w_index;

  tlb_op_ctrl #(.TLBNUM(16), .IDX_W(IDX_W)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op), .req_pc(req_pc),
    .req_ready(req_ready), .wb_ex(wb_ex), .mtc0_hazard(mtc0_hazard),
    .c0_entryhi(c0_entryhi), .c0_index(c0_index), .s_vpn2(s_vpn2), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .r_index(r_index), .tlbr_we(tlbr_we),
    .tlbp_we(tlbp_we), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index), .we(we),
    .w_index(w_index), .refetch_req(refetch_req), .refetch_pc(refetch_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req_ready;
    logic        busy;
    logic [18:0] s_vpn2;
    logic [7:0]  s_asid;
    logic [3:0]  r_index;
    logic        tlbr_we;
    logic        tlbp_we;
    logic        tlbp_found;
    logic [3:0]  tlbp_index;
    logic        we;
    logic [3:0]  w_index;
    logic        refetch_req;
    logic [31:0] refetch_pc;
  } outs_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] pc;
    logic [31:0] eh;
    logic [31:0] idx;
    int          hz;
    logic        e_found;
    logic [3:0]  e_idx;
    logic [31:0] e_rpc;
  } vec_t;

  outs_t act;
  assign act = {req_ready, busy, s_vpn2, s_asid, r_index, tlbr_we, tlbp_we, tlbp_found,
                tlbp_index, we, w_index, refetch_req, refetch_pc};

  int n_chk = 0;
  int n_err = 0;
  int since_rst = 0;

  // TLB array model: first matching entry in index order wins
  logic [18:0] tlb_vpn2 [16];
  logic [7:0]  tlb_asid [16];

  function automatic logic [4:0] tlb_find(input logic [18:0] v, input logic [7:0] a);
    for (int i = 0; i < 16; i++)
      if (tlb_vpn2[i] == v && tlb_asid[i] == a) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  always_comb {s_found, s_index} = tlb_find(s_vpn2, s_asid);

  // Random-replacement index follows from the number of clock edges since reset
  always @(posedge clk) begin
    if (!resetn) since_rst <= 0;
    else         since_rst <= since_rst + 1;
  end

  function automatic logic [3:0] exp_rand();
    return 4'(15 - (since_rst % 16));
  endfunction

  function automatic outs_t mk_exec(input logic [1:0] op, input logic [31:0] eh,
                                    input logic [31:0] idx, input logic [3:0] wr);
    outs_t o = '0;
    o.busy = 1'b1;
    case (op)
      2'd0: begin o.s_vpn2 = eh[31:13]; o.s_asid = eh[7:0]; end
      2'd1: begin o.r_index = idx[3:0]; o.tlbr_we = 1'b1; end
      2'd2: begin o.we = 1'b1; o.w_index = idx[3:0]; end
      default: begin o.we = 1'b1; o.w_index = wr; end
    endcase
    return o;
  endfunction

  function automatic outs_t mk_done(input logic [1:0] op, input logic found,
                                    input logic [3:0] hidx, input logic [31:0] rpc);
    outs_t o = '0;
    o.busy = 1'b1;
    o.req_ready = 1'b1;
    if (op == 2'd0) begin
      o.tlbp_we = 1'b1; o.tlbp_found = found; o.tlbp_index = hidx;
    end else begin
      o.refetch_req = 1'b1; o.refetch_pc = rpc;
    end
    return o;
  endfunction

  function automatic outs_t busy_only();
    outs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  task automatic chk(input string tag, input outs_t exp);
    @(negedge clk);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction; starts and ends one time unit after a rising edge
  task automatic do_op(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] eh,
                       input logic [31:0] idx, input int hz, input logic e_found,
                       input logic [3:0] e_idx, input logic [31:0] e_rpc, input string tag);
    c0_entryhi = eh; c0_index = idx;
    req_valid = 1'b1; req_op = op; req_pc = pc; mtc0_hazard = (hz > 0);
    chk({tag, "/idle"}, busy_only());
    step();
    for (int i = 0; i < hz; i++) begin
      if (i == hz - 1) mtc0_hazard = 1'b0;
      chk({tag, "/wait"}, busy_only());
      step();
    end
    chk({tag, "/exec"}, mk_exec(op, eh, idx, exp_rand()));
    step();
    chk({tag, "/done"}, mk_done(op, e_found, e_idx, e_rpc));
    step();
    req_valid = 1'b0;
    chk({tag, "/after"}, '0);
    step();
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk(tag, '0);
      step();
    end
  endtask

  task automatic do_abort(input logic [1:0] op);
    req_valid = 1'b1; req_op = op; req_pc = $urandom; mtc0_hazard = 1'b1; wb_ex = 1'b0;
    chk("abort/idle", busy_only());
    step();
    wb_ex = 1'b1;
    chk("abort/wait", busy_only());
    step();
    req_valid = 1'b0; wb_ex = 1'b0; mtc0_hazard = 1'b0;
    idle_cycles(3, "abort/quiet");
  endtask

  task automatic do_ignore(input logic [1:0] op);
    req_valid = 1'b1; req_op = op; req_pc = $urandom; mtc0_hazard = 1'b0; wb_ex = 1'b1;
    chk("ignore/idle", busy_only());
    step();
    req_valid = 1'b0; wb_ex = 1'b0;
    idle_cycles(3, "ignore/quiet");
  endtask

  task automatic do_reset_in_exec(input logic [1:0] op);
    c0_entryhi = $urandom; c0_index = $urandom;
    req_valid = 1'b1; req_op = op; req_pc = $urandom; mtc0_hazard = 1'b0;
    chk("rstx/idle", busy_only());
    step();
    resetn = 1'b0;
    chk("rstx/exec", mk_exec(op, c0_entryhi, c0_index, exp_rand()));
    step();
    resetn = 1'b1; req_valid = 1'b0;
    idle_cycles(3, "rstx/after");
  endtask

  vec_t tbl [6];

  initial begin
    logic [1:0]  op;
    logic [31:0] pc, eh, idx;
    logic [4:0]  hit;
    int          k, mode;

    for (int i = 0; i < 16; i++) begin
      tlb_vpn2[i] = 19'h10000 + 19'(i);
      tlb_asid[i] = 8'(i + 16);
    end
    tlb_vpn2[7]  = 19'h00201; tlb_asid[7]  = 8'h05;
    tlb_vpn2[12] = 19'h7ffff; tlb_asid[12] = 8'hff;

    tbl[0] = '{2'd0, 32'h8000_1000, 32'h0040_2005, 32'h0,         0, 1'b1, 4'd7,  32'h0};
    tbl[1] = '{2'd0, 32'h8000_2000, 32'h0040_2006, 32'h0,         0, 1'b0, 4'd0,  32'h0};
    tbl[2] = '{2'd2, 32'hBFC0_0100, 32'h0,         32'h8000_0003, 0, 1'b0, 4'd0,  32'hBFC0_0104};
    tbl[3] = '{2'd1, 32'h8000_0000, 32'h0,         32'h7FFF_FFF9, 3, 1'b0, 4'd0,  32'h8000_0004};
    tbl[4] = '{2'd2, 32'hFFFF_FFFC, 32'h0,         32'h0000_000F, 1, 1'b0, 4'd0,  32'h0000_0000};
    tbl[5] = '{2'd0, 32'h0000_0040, 32'hFFFF_E0FF, 32'h0,         2, 1'b1, 4'd12, 32'h0};

    resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_pc = '0; wb_ex = 1'b0;
    mtc0_hazard = 1'b0; c0_entryhi = '0; c0_index = '0;
    step();
    chk("reset", '0);
    step();
    resetn = 1'b1;

    // TLBWR five edges after release, and again sixteen edges later
    idle_cycles(4, "pre_tlbwr");
    do_op(2'd3, 32'h8000_0100, 32'h0, 32'h0, 0, 1'b0, 4'd0, 32'h8000_0104, "tlbwr1");
    idle_cycles(12, "gap_tlbwr");
    do_op(2'd3, 32'h8000_0200, 32'h0, 32'h0, 0, 1'b0, 4'd0, 32'h8000_0204, "tlbwr2");

    for (int i = 0; i < 6; i++)
      do_op(tbl[i].op, tbl[i].pc, tbl[i].eh, tbl[i].idx, tbl[i].hz,
            tbl[i].e_found, tbl[i].e_idx, tbl[i].e_rpc, $sformatf("vec%0d", i));

    do_abort(2'd2);
    do_ignore(2'd3);
    do_reset_in_exec(2'd2);

    for (int n = 0; n < 80; n++) begin
      op   = 2'($urandom);
      pc   = ($urandom % 8 == 0) ? 32'hFFFF_FFFC : $urandom;
      idx  = $urandom;
      eh   = $urandom;
      mode = $urandom % 10;
      if ($urandom % 2 == 1) begin
        k  = $urandom % 16;
        eh = {tlb_vpn2[k], 5'($urandom), tlb_asid[k]};
      end
      hit = tlb_find(eh[31:13], eh[7:0]);
      if (mode == 0)      do_abort(op);
      else if (mode == 1) do_ignore(op);
      else if (mode == 2) do_reset_in_exec(op);
      else
        do_op(op, pc, eh, idx, $urandom % 4, hit[4], hit[4] ? hit[3:0] : 4'd0, pc + 32'd4,
              $sformatf("rnd%0d", n));
      idle_cycles($urandom % 3, "rnd/gap");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
